avr_dmem_arbiter: RTL

Arbitrates the single-port data SRAM between the CPU data port (PUSH/POP/RCALL/RET and future LD/ST) and one auxiliary requester (debug/DMA). The CPU has priority by default. A starvation counter guarantees the auxiliary port a slot, and an aux lock supports atomic multi-byte bursts. The block drives the CPU stall request when the CPU loses arbitration, and it sits between avr_cpu and the data SRAM.

---
 rtl/avr_dmem_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/avr_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : avr_dmem_arbiter
// Description : Single-port data SRAM arbiter between the CPU data port and
//               one auxiliary (debug/DMA) requester, with a starvation guard
//               and an aux lock for atomic multi-byte bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module avr_dmem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int AW           = 16
) (
    input  logic          CLK,
    input  logic          RST,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    output logic [7:0]    cpu_rdata,

    input  logic          aux_req,
    input  logic          aux_we,
    input  logic [AW-1:0] aux_addr,
    input  logic [7:0]    aux_wdata,
    input  logic          aux_lock,
    output logic          aux_gnt,
    output logic          aux_rvalid,
    output logic [7:0]    aux_rdata,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata
);

    localparam int            CW      = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] C_LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_CPU  = 2'd1,
        SEL_AUX  = 2'd2
    } sel_e;

    sel_e          sel;
    logic [CW-1:0] starve_cnt_q, starve_cnt_d;
    logic          lock_held_q,  lock_held_d;
    logic          cpu_rvalid_q, cpu_rvalid_d;
    logic          aux_rvalid_q, aux_rvalid_d;

    // Aux wins when it holds the lock, has waited long enough, or is alone.
    always_comb begin
        sel = SEL_NONE;
        if (!RST) begin
            if (aux_req && (lock_held_q || (starve_cnt_q >= C_LIMIT) || !cpu_req)) begin
                sel = SEL_AUX;
            end else if (cpu_req) begin
                sel = SEL_CPU;
            end
        end
    end

    assign cpu_gnt   = (sel == SEL_CPU);
    assign aux_gnt   = (sel == SEL_AUX);
    assign cpu_stall = cpu_req & ~cpu_gnt;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (sel)
            SEL_CPU: begin
                mem_en    = 1'b1;
                mem_we    = cpu_we;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end
            SEL_AUX: begin
                mem_en    = 1'b1;
                mem_we    = aux_we;
                mem_addr  = aux_addr;
                mem_wdata = aux_wdata;
            end
            default: begin
                mem_en = 1'b0;
            end
        endcase
    end

    always_comb begin
        starve_cnt_d = '0;
        if (aux_req && !aux_gnt) begin
            starve_cnt_d = (starve_cnt_q >= C_LIMIT) ? C_LIMIT : starve_cnt_q + CW'(1);
        end
        lock_held_d  = aux_gnt & aux_lock;
        cpu_rvalid_d = cpu_gnt & ~cpu_we;
        aux_rvalid_d = aux_gnt & ~aux_we;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            starve_cnt_q <= '0;
            lock_held_q  <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            aux_rvalid_q <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            lock_held_q  <= lock_held_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            aux_rvalid_q <= aux_rvalid_d;
        end
    end

    // Gating with RST drops a read whose data would return in the reset cycle.
    assign cpu_rvalid = cpu_rvalid_q & ~RST;
    assign aux_rvalid = aux_rvalid_q & ~RST;
    assign cpu_rdata  = mem_rdata;
    assign aux_rdata  = mem_rdata;

endmodule
`default_nettype wire
